// File: rtl/issue_split_if.sv
// Fetch-to-issue bundle interface: fetched bundle and control flowing in,
// split issue slots and the fetch interlock flowing out.
interface issue_split_if;
  logic [63:0] bundle_in;
  logic [31:0] bundle_pc;
  logic        branch_flag;
  logic        stall_in;
  logic        interlock;
  logic [31:0] issue0_inst;
  logic [31:0] issue1_inst;
  logic [31:0] issue0_pc;
  logic [31:0] issue1_pc;
  logic        issue0_valid;
  logic        issue1_valid;

  modport master (
    output bundle_in, bundle_pc, branch_flag, stall_in,
    input  interlock, issue0_inst, issue1_inst, issue0_pc, issue1_pc,
           issue0_valid, issue1_valid
  );

  modport slave (
    input  bundle_in, bundle_pc, branch_flag, stall_in,
    output interlock, issue0_inst, issue1_inst, issue0_pc, issue1_pc,
           issue0_valid, issue1_valid
  );
endinterface

// File: rtl/issue_split.sv
// Dual-issue splitter: issues a two-slot bundle in one cycle, or over two
// cycles when slot1 reads the register slot0 writes (RAW inside the bundle).
package inst_package;
  localparam logic [5:0] Nop = 6'h3F;
endpackage

module issue_split
  import inst_package::*;
(
  input  logic          clk,
  input  logic          rstn,
  issue_split_if.slave  bus
);

  localparam logic [31:0] NOP_WORD = {Nop, 26'b0};

  typedef enum logic [0:0] {
    PASS   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] hold_inst_r;
  logic [31:0] hold_pc_r;
  logic [31:0] issue0_inst_r;
  logic [31:0] issue1_inst_r;
  logic [31:0] issue0_pc_r;
  logic [31:0] issue1_pc_r;
  logic        issue0_valid_r;
  logic        issue1_valid_r;

  logic [31:0] slot0_s;
  logic [31:0] slot1_s;
  logic        real0_s;
  logic        real1_s;
  logic        hazard_s;
  logic [31:0] inst0_s;
  logic [31:0] inst1_s;
  logic [31:0] pc0_s;
  logic [31:0] pc1_s;
  logic        unused_pc_msb_s;

  assign unused_pc_msb_s = bus.bundle_pc[31];

  // Slot decode, bubble normalisation and intra-bundle RAW detection.
  always_comb begin
    slot0_s  = bus.bundle_in[63:32];
    slot1_s  = bus.bundle_in[31:0];
    real0_s  = (slot0_s[31:26] != Nop);
    real1_s  = (slot1_s[31:26] != Nop);
    hazard_s = real0_s && real1_s && (slot0_s[25:21] != 5'd0) &&
               ((slot0_s[25:21] == slot1_s[20:16]) ||
                (slot0_s[25:21] == slot1_s[15:11]));
    inst0_s  = real0_s ? slot0_s : NOP_WORD;
    inst1_s  = real1_s ? slot1_s : NOP_WORD;
    pc0_s    = real0_s ? {bus.bundle_pc[30:0], 1'b0} : 32'd0;
    pc1_s    = real1_s ? {bus.bundle_pc[30:0], 1'b1} : 32'd0;
  end

  // Issue FSM; branch beats stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r        <= PASS;
      hold_inst_r    <= NOP_WORD;
      hold_pc_r      <= 32'd0;
      issue0_inst_r  <= NOP_WORD;
      issue1_inst_r  <= NOP_WORD;
      issue0_pc_r    <= 32'd0;
      issue1_pc_r    <= 32'd0;
      issue0_valid_r <= 1'b0;
      issue1_valid_r <= 1'b0;
    end else if (bus.branch_flag) begin
      state_r        <= PASS;
      hold_inst_r    <= NOP_WORD;
      hold_pc_r      <= 32'd0;
      issue0_inst_r  <= NOP_WORD;
      issue1_inst_r  <= NOP_WORD;
      issue0_pc_r    <= 32'd0;
      issue1_pc_r    <= 32'd0;
      issue0_valid_r <= 1'b0;
      issue1_valid_r <= 1'b0;
    end else if (bus.stall_in) begin
      state_r        <= state_r;
    end else begin
      case (state_r)
        PASS: begin
          issue0_inst_r  <= inst0_s;
          issue0_pc_r    <= pc0_s;
          issue0_valid_r <= real0_s;
          if (hazard_s) begin
            state_r        <= SECOND;
            hold_inst_r    <= slot1_s;
            hold_pc_r      <= {bus.bundle_pc[30:0], 1'b1};
            issue1_inst_r  <= NOP_WORD;
            issue1_pc_r    <= 32'd0;
            issue1_valid_r <= 1'b0;
          end else begin
            state_r        <= PASS;
            issue1_inst_r  <= inst1_s;
            issue1_pc_r    <= pc1_s;
            issue1_valid_r <= real1_s;
          end
        end
        SECOND: begin
          state_r        <= PASS;
          issue0_inst_r  <= hold_inst_r;
          issue0_pc_r    <= hold_pc_r;
          issue0_valid_r <= 1'b1;
          issue1_inst_r  <= NOP_WORD;
          issue1_pc_r    <= 32'd0;
          issue1_valid_r <= 1'b0;
          hold_inst_r    <= NOP_WORD;
          hold_pc_r      <= 32'd0;
        end
        default: begin
          state_r        <= PASS;
          issue0_inst_r  <= NOP_WORD;
          issue1_inst_r  <= NOP_WORD;
          issue0_pc_r    <= 32'd0;
          issue1_pc_r    <= 32'd0;
          issue0_valid_r <= 1'b0;
          issue1_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Fetch must see only stall_in while reset is held, even if state is stale.
  assign bus.interlock    = ((state_r == SECOND) && rstn) || bus.stall_in;
  assign bus.issue0_inst  = issue0_inst_r;
  assign bus.issue1_inst  = issue1_inst_r;
  assign bus.issue0_pc    = issue0_pc_r;
  assign bus.issue1_pc    = issue1_pc_r;
  assign bus.issue0_valid = issue0_valid_r;
  assign bus.issue1_valid = issue1_valid_r;

endmodule

// File: tb/tb_issue_split.sv
// Directed self-checking bench for issue_split with hand-computed expectations.
module tb_issue_split;
  localparam logic [5:0]  NOP_OP = 6'h3F;
  localparam logic [5:0]  ALU_OP = 6'h01;
  localparam logic [31:0] NOPW   = {NOP_OP, 26'b0};

  logic clk;
  logic rstn;
  int   checks_cnt;
  int   errors_cnt;

  issue_split_if bus ();

  issue_split u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h000};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] pc);
    bus.bundle_in = {s0, s1};
    bus.bundle_pc = pc;
  endtask

  logic [31:0] a0, a1;

  initial begin
    checks_cnt      = 0;
    errors_cnt      = 0;
    rstn            = 1'b0;
    bus.branch_flag = 1'b0;
    bus.stall_in    = 1'b1;
    drive(NOPW, NOPW, 32'd0);
    step();
    check_eq("rst_v0", bus.issue0_valid, 1'b0);
    check_eq("rst_v1", bus.issue1_valid, 1'b0);
    check_eq("rst_inst0", bus.issue0_inst, NOPW);
    check_eq("rst_inst1", bus.issue1_inst, NOPW);
    check_eq("rst_pc0", bus.issue0_pc, 32'd0);
    check_eq("rst_pc1", bus.issue1_pc, 32'd0);
    check_eq("rst_ilk_stall", bus.interlock, 1'b1);
    bus.stall_in = 1'b0;
    #1;
    check_eq("rst_ilk_nostall", bus.interlock, 1'b0);
    rstn = 1'b1;

    // independent pair
    a0 = mk(ALU_OP, 5'd3, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd7, 5'd4, 5'd6);
    drive(a0, a1, 32'd5);
    step();
    check_eq("ind_v0", bus.issue0_valid, 1'b1);
    check_eq("ind_v1", bus.issue1_valid, 1'b1);
    check_eq("ind_pc0", bus.issue0_pc, 32'd10);
    check_eq("ind_pc1", bus.issue1_pc, 32'd11);
    check_eq("ind_inst0", bus.issue0_inst, a0);
    check_eq("ind_inst1", bus.issue1_inst, a1);
    check_eq("ind_ilk", bus.interlock, 1'b0);

    // RAW on rs1
    a0 = mk(ALU_OP, 5'd3, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd8, 5'd3, 5'd6);
    drive(a0, a1, 32'd2);
    step();
    check_eq("raw1_v0", bus.issue0_valid, 1'b1);
    check_eq("raw1_pc0", bus.issue0_pc, 32'd4);
    check_eq("raw1_inst0", bus.issue0_inst, a0);
    check_eq("raw1_v1", bus.issue1_valid, 1'b0);
    check_eq("raw1_inst1", bus.issue1_inst, NOPW);
    check_eq("raw1_ilk", bus.interlock, 1'b1);
    step();
    check_eq("raw2_v0", bus.issue0_valid, 1'b1);
    check_eq("raw2_pc0", bus.issue0_pc, 32'd5);
    check_eq("raw2_inst0", bus.issue0_inst, a1);
    check_eq("raw2_v1", bus.issue1_valid, 1'b0);
    check_eq("raw2_ilk", bus.interlock, 1'b0);

    // RAW on rs2, pc bit 31 dropped
    a0 = mk(ALU_OP, 5'd12, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd8, 5'd4, 5'd12);
    drive(a0, a1, 32'h8000_0009);
    step();
    check_eq("rs2_pc0", bus.issue0_pc, 32'd18);
    check_eq("rs2_v1", bus.issue1_valid, 1'b0);
    check_eq("rs2_ilk", bus.interlock, 1'b1);
    step();
    check_eq("rs2_pc0b", bus.issue0_pc, 32'd19);
    check_eq("rs2_inst0b", bus.issue0_inst, a1);

    // r0 exemption
    a0 = mk(ALU_OP, 5'd0, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd5, 5'd0, 5'd0);
    drive(a0, a1, 32'd7);
    step();
    check_eq("r0_v0", bus.issue0_valid, 1'b1);
    check_eq("r0_v1", bus.issue1_valid, 1'b1);
    check_eq("r0_pc1", bus.issue1_pc, 32'd15);
    check_eq("r0_ilk", bus.interlock, 1'b0);

    // Nop slot0 with matching rd field: no split, slot0 normalised
    a0 = mk(NOP_OP, 5'd3, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd5, 5'd3, 5'd3);
    drive(a0, a1, 32'd8);
    step();
    check_eq("nop_v0", bus.issue0_valid, 1'b0);
    check_eq("nop_inst0", bus.issue0_inst, NOPW);
    check_eq("nop_v1", bus.issue1_valid, 1'b1);
    check_eq("nop_pc1", bus.issue1_pc, 32'd17);
    check_eq("nop_ilk", bus.interlock, 1'b0);

    // branch during SECOND
    a0 = mk(ALU_OP, 5'd5, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd6, 5'd5, 5'd2);
    drive(a0, a1, 32'd20);
    step();
    check_eq("br_split_ilk", bus.interlock, 1'b1);
    bus.branch_flag = 1'b1;
    drive(mk(ALU_OP, 5'd1, 5'd2, 5'd3), mk(ALU_OP, 5'd4, 5'd2, 5'd3), 32'd25);
    step();
    check_eq("br_v0", bus.issue0_valid, 1'b0);
    check_eq("br_v1", bus.issue1_valid, 1'b0);
    check_eq("br_inst0", bus.issue0_inst, NOPW);
    check_eq("br_ilk", bus.interlock, 1'b0);
    bus.branch_flag = 1'b0;
    a0 = mk(ALU_OP, 5'd10, 5'd11, 5'd12);
    a1 = mk(ALU_OP, 5'd13, 5'd14, 5'd15);
    drive(a0, a1, 32'd30);
    step();
    check_eq("br_next_inst0", bus.issue0_inst, a0);
    check_eq("br_next_pc0", bus.issue0_pc, 32'd60);
    check_eq("br_next_inst1", bus.issue1_inst, a1);

    // stall hold for three cycles
    a0 = mk(ALU_OP, 5'd2, 5'd3, 5'd4);
    a1 = mk(ALU_OP, 5'd5, 5'd6, 5'd7);
    drive(a0, a1, 32'd40);
    step();
    check_eq("st_pre_pc0", bus.issue0_pc, 32'd80);
    bus.stall_in = 1'b1;
    drive(mk(ALU_OP, 5'd9, 5'd1, 5'd1), mk(ALU_OP, 5'd8, 5'd1, 5'd1), 32'd41);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("st_pc0", bus.issue0_pc, 32'd80);
      check_eq("st_inst0", bus.issue0_inst, a0);
      check_eq("st_inst1", bus.issue1_inst, a1);
      check_eq("st_ilk", bus.interlock, 1'b1);
    end
    bus.stall_in = 1'b0;
    step();
    check_eq("st_res_pc0", bus.issue0_pc, 32'd82);
    check_eq("st_res_inst0", bus.issue0_inst, mk(ALU_OP, 5'd9, 5'd1, 5'd1));
    check_eq("st_res_ilk", bus.interlock, 1'b0);

    // branch overrides stall
    bus.stall_in    = 1'b1;
    bus.branch_flag = 1'b1;
    step();
    check_eq("brst_v0", bus.issue0_valid, 1'b0);
    check_eq("brst_v1", bus.issue1_valid, 1'b0);
    bus.stall_in    = 1'b0;
    bus.branch_flag = 1'b0;

    // reset while in SECOND
    a0 = mk(ALU_OP, 5'd9, 5'd1, 5'd2);
    a1 = mk(ALU_OP, 5'd4, 5'd3, 5'd9);
    drive(a0, a1, 32'd50);
    step();
    check_eq("rs_split_pc0", bus.issue0_pc, 32'd100);
    check_eq("rs_split_ilk", bus.interlock, 1'b1);
    rstn = 1'b0;
    #1;
    check_eq("rs_ilk_low", bus.interlock, 1'b0);
    step();
    check_eq("rs_v0", bus.issue0_valid, 1'b0);
    check_eq("rs_v1", bus.issue1_valid, 1'b0);
    check_eq("rs_pc0", bus.issue0_pc, 32'd0);
    check_eq("rs_pc1", bus.issue1_pc, 32'd0);
    rstn = 1'b1;
    drive(NOPW, NOPW, 32'd51);
    #1;
    check_eq("rs_ilk_pass", bus.interlock, 1'b0);
    step();
    check_eq("rs_post_v0", bus.issue0_valid, 1'b0);
    check_eq("rs_post_inst0", bus.issue0_inst, NOPW);
    check_eq("rs_post_v1", bus.issue1_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
